melody_sequencer: RTL and testbench

Plays a note table at a programmable tempo, one table entry per step.
- Steps a table address and holds each entry for a fixed number of clocks.
- Emits the current note index plus a note-onset strobe for the tone generator.
- Successor to the fixed combinational melody table: adds tempo, pause, loop, restart, and note merging across repeated entries.
- Sits between the melody table (combinational read, driven externally or by melody_table) and the tone/divider stage.

---
 rtl/melody_pkg.sv | 24 ++
 rtl/melody_table.sv | 45 ++++
 rtl/melody_sequencer.sv | 133 +++++++++++++
 tb/tb_melody_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
`default_nettype none
// ============================================================================
// Module : melody_pkg
// Brief  : Shared note codes and sequencer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package melody_pkg;

    localparam logic [3:0] NOTE_REST = 4'b0000;
    localparam logic [3:0] DO        = 4'b1000;
    localparam logic [3:0] RE        = 4'b1001;
    localparam logic [3:0] MI        = 4'b1010;
    localparam logic [3:0] SOL       = 4'b1100;
    localparam logic [3:0] LA        = 4'b1101;
    localparam logic [3:0] DO_HI     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/melody_table.sv
`default_nettype none
// ============================================================================
// Module : melody_table
// Brief  : Combinational note table; addresses not listed read as a rest.
// Rev    : 1.0  initial release
// ============================================================================
module melody_table
    import melody_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int NOTE_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [NOTE_W-1:0] data
);

    always_comb begin
        data = NOTE_W'(NOTE_REST);
        case (addr)
            ADDR_W'(1):  data = NOTE_W'(DO);
            ADDR_W'(2):  data = NOTE_W'(NOTE_REST);
            ADDR_W'(3):  data = NOTE_W'(RE);
            ADDR_W'(4):  data = NOTE_W'(MI);
            ADDR_W'(5):  data = NOTE_W'(MI);
            ADDR_W'(6):  data = NOTE_W'(SOL);
            ADDR_W'(7):  data = NOTE_W'(LA);
            ADDR_W'(8):  data = NOTE_W'(NOTE_REST);
            // Four equal entries: played as one sustained note
            ADDR_W'(9):  data = NOTE_W'(SOL);
            ADDR_W'(10): data = NOTE_W'(SOL);
            ADDR_W'(11): data = NOTE_W'(SOL);
            ADDR_W'(12): data = NOTE_W'(SOL);
            ADDR_W'(13): data = NOTE_W'(NOTE_REST);
            ADDR_W'(14): data = NOTE_W'(DO_HI);
            ADDR_W'(15): data = NOTE_W'(LA);
            ADDR_W'(16): data = NOTE_W'(SOL);
            ADDR_W'(17): data = NOTE_W'(MI);
            ADDR_W'(18): data = NOTE_W'(RE);
            ADDR_W'(19): data = NOTE_W'(DO);
            default:     data = NOTE_W'(NOTE_REST);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module : melody_sequencer
// Brief  : Steps a note table at a programmable tempo and emits note + onset.
// Rev    : 1.0  initial release
// ============================================================================
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int NOTE_W     = 4,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 63,
    parameter int TICK_W     = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [TICK_W-1:0] step_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_data,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              note_start,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]        c_st_idle   = IDLE;
    localparam logic [1:0]        c_st_play   = PLAY;
    localparam logic [1:0]        c_st_paused = PAUSED;
    localparam logic [ADDR_W-1:0] c_first     = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(LAST_ADDR);
    localparam logic [TICK_W-1:0] c_one       = TICK_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [TICK_W-1:0] r_cnt;
    logic [TICK_W-1:0] r_step_len;
    logic [NOTE_W-1:0] r_prev;
    logic [NOTE_W-1:0] r_note;
    logic              r_note_start;
    logic              r_done;

    logic              w_run;
    logic              w_cnt_zero;
    logic              w_cnt_last;
    logic              w_addr_last;
    logic              w_onset;
    logic [TICK_W-1:0] w_step_len_q;

    // Playback advances only in cycles where pause is low, so PLAY and
    // PAUSED freeze and resume on exactly the cycles pause changes.
    assign w_run        = (r_state != c_st_idle) && !pause;
    assign w_cnt_zero   = (r_cnt == '0);
    assign w_cnt_last   = (r_cnt == (r_step_len - c_one));
    assign w_addr_last  = (r_addr == c_last);
    assign w_onset      = w_cnt_zero && (rom_data != '0) && (rom_data != r_prev);
    assign w_step_len_q = (step_len == '0) ? c_one : step_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_addr       <= c_first;
            r_cnt        <= '0;
            r_step_len   <= c_one;
            r_prev       <= '0;
            r_note       <= '0;
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
        end else if (stop) begin
            r_state      <= c_st_idle;
            r_addr       <= c_first;
            r_cnt        <= '0;
            r_note       <= '0;
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
        end else if (start) begin
            r_state      <= c_st_play;
            r_addr       <= c_first;
            r_cnt        <= '0;
            r_step_len   <= w_step_len_q;
            r_prev       <= '0;
            r_note       <= '0;
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_note       <= '0;
            r_note_start <= 1'b0;
            r_done       <= 1'b0;
            if (r_state != c_st_idle) begin
                r_state <= pause ? c_st_paused : c_st_play;
            end
            if (w_run) begin
                r_note       <= rom_data;
                r_note_start <= w_onset;
                if (w_cnt_zero) begin
                    r_prev <= rom_data;
                end
                if (w_cnt_last) begin
                    r_cnt <= '0;
                    if (w_addr_last) begin
                        r_addr <= c_first;
                        // Clearing prev after the last step lets a looped
                        // first note re-trigger even if it equals the last.
                        if (loop_en) begin
                            r_prev <= '0;
                        end else begin
                            r_state <= c_st_idle;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end else begin
                    r_cnt <= r_cnt + c_one;
                end
            end
        end
    end

    assign rom_addr   = r_addr;
    assign note       = r_note;
    assign note_valid = (r_note != '0);
    assign note_start = r_note_start;
    assign busy       = (r_state != c_st_idle);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_melody_sequencer
// Brief  : Scoreboard bench: per-cycle expectations queued at stimulus time.
// Rev    : 1.0  initial release
// ============================================================================
module tb_melody_sequencer;

    localparam int ADDR_W = 7;
    localparam int NOTE_W = 4;
    localparam int TICK_W = 24;

    localparam int S_ADDR = 0, S_NOTE = 1, S_VALID = 2, S_NSTART = 3, S_BUSY = 4, S_DONE = 5;
    localparam int S_ADDR3 = 6, S_NOTE3 = 7, S_NSTART3 = 8, S_BUSY3 = 9, S_DONE3 = 10;

    typedef struct {
        int    cyc;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic              start3 = 1'b0, stop3 = 1'b0;
    logic [TICK_W-1:0] step_len = '0;
    logic [ADDR_W-1:0] rom_addr, rom_addr3;
    logic [NOTE_W-1:0] rom_data, rom_data3, note, note3;
    logic              note_valid, note_start, busy, done;
    logic              note_valid3, note_start3, busy3, done3;
    logic [NOTE_W-1:0] tbl  [0:127];
    logic [NOTE_W-1:0] tbl3 [0:127];
    logic [ADDR_W-1:0] mt_addr = '0;
    logic [NOTE_W-1:0] mt_data;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   base = 0;
    exp_t sb[$];
    exp_t mon_e;

    int mt_a [10] = '{0, 1, 2, 3, 6, 9, 12, 13, 14, 100};
    int mt_d [10] = '{0, 8, 0, 9, 12, 12, 12, 0, 15, 0};

    assign rom_data  = tbl[rom_addr];
    assign rom_data3 = tbl3[rom_addr3];

    melody_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .step_len(step_len), .rom_addr(rom_addr),
        .rom_data(rom_data), .note(note), .note_valid(note_valid),
        .note_start(note_start), .busy(busy), .done(done)
    );

    melody_sequencer #(.LAST_ADDR(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop3), .pause(pause),
        .loop_en(loop_en), .step_len(step_len), .rom_addr(rom_addr3),
        .rom_data(rom_data3), .note(note3), .note_valid(note_valid3),
        .note_start(note_start3), .busy(busy3), .done(done3)
    );

    melody_table u_table (
        .addr(mt_addr),
        .data(mt_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int sig_val(input int s);
        case (s)
            S_ADDR:    return int'(rom_addr);
            S_NOTE:    return int'(note);
            S_VALID:   return int'(note_valid);
            S_NSTART:  return int'(note_start);
            S_BUSY:    return int'(busy);
            S_DONE:    return int'(done);
            S_ADDR3:   return int'(rom_addr3);
            S_NOTE3:   return int'(note3);
            S_NSTART3: return int'(note_start3);
            S_BUSY3:   return int'(busy3);
            S_DONE3:   return int'(done3);
            default:   return -1;
        endcase
    endfunction

    task automatic sb_push(input int rel, input int sig, input int val, input string tag);
        exp_t e;
        int   i;
        e.cyc = base + rel;
        e.sig = sig;
        e.val = val;
        e.tag = $sformatf("%s_c%0d", tag, rel);
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > e.cyc) i--;
        sb.insert(i, e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) check({mon_e.tag, "_missed"}, -1, mon_e.val);
            else check(mon_e.tag, sig_val(mon_e.sig), mon_e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_rel(input int rel);
        while (cyc < base + rel) tick();
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 128; i++) begin
            tbl[i]  = '0;
            tbl3[i] = '0;
        end
    endtask

    task automatic stop_main(input int rel);
        goto_rel(rel);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_tbl();

        for (int i = 0; i < 10; i++) begin
            mt_addr = ADDR_W'(mt_a[i]);
            #1;
            check($sformatf("table_a%0d", mt_a[i]), int'(mt_data), mt_d[i]);
        end

        // Reset values
        repeat (3) tick();
        rst  = 1'b0;
        base = cyc;
        for (int r = 0; r < 2; r++) begin
            sb_push(r, S_ADDR, 1, "rst_addr");
            sb_push(r, S_NOTE, 0, "rst_note");
            sb_push(r, S_VALID, 0, "rst_valid");
            sb_push(r, S_NSTART, 0, "rst_nstart");
            sb_push(r, S_BUSY, 0, "rst_busy");
            sb_push(r, S_DONE, 0, "rst_done");
        end
        goto_rel(3);

        // Basic stepping: {1:8, 2:0, 3:9}, step_len=4
        clear_tbl();
        tbl[1] = 4'd8; tbl[3] = 4'd9;
        step_len = 24'd4;
        base = cyc; start = 1'b1;
        sb_push(1, S_ADDR, 1, "basic_addr"); sb_push(4, S_ADDR, 1, "basic_addr");
        sb_push(5, S_ADDR, 2, "basic_addr"); sb_push(8, S_ADDR, 2, "basic_addr");
        sb_push(9, S_ADDR, 3, "basic_addr"); sb_push(12, S_ADDR, 3, "basic_addr");
        sb_push(1, S_BUSY, 1, "basic_busy");
        sb_push(3, S_VALID, 1, "basic_valid"); sb_push(7, S_VALID, 0, "basic_valid");
        for (int r = 1; r <= 13; r++) begin
            sb_push(r, S_NOTE, (r >= 2 && r <= 5) ? 8 : ((r >= 10) ? 9 : 0), "basic_note");
            sb_push(r, S_NSTART, (r == 2 || r == 10) ? 1 : 0, "basic_nstart");
        end
        sb_push(15, S_BUSY, 0, "stop_busy");
        sb_push(15, S_NOTE, 0, "stop_note");
        sb_push(15, S_DONE, 0, "stop_done");
        tick(); start = 1'b0;
        stop_main(14);

        // Merge of repeated entries 9..12, step_len=2
        clear_tbl();
        for (int a = 9; a <= 12; a++) tbl[a] = 4'd12;
        step_len = 24'd2;
        base = cyc; start = 1'b1;
        sb_push(17, S_ADDR, 9, "merge_addr"); sb_push(25, S_ADDR, 13, "merge_addr");
        for (int r = 16; r <= 27; r++) begin
            sb_push(r, S_NOTE, (r >= 18 && r <= 25) ? 12 : 0, "merge_note");
            sb_push(r, S_NSTART, (r == 18) ? 1 : 0, "merge_nstart");
        end
        tick(); start = 1'b0;
        stop_main(28);

        // Pause at cnt=2 for 10 cycles
        clear_tbl();
        tbl[1] = 4'd8; tbl[2] = 4'd9;
        step_len = 24'd4;
        base = cyc; start = 1'b1;
        for (int r = 3; r <= 14; r++) sb_push(r, S_ADDR, 1, "pause_addr");
        sb_push(15, S_ADDR, 2, "pause_addr");
        for (int r = 2; r <= 16; r++) begin
            sb_push(r, S_NOTE, (r <= 3 || r == 14 || r == 15) ? 8 : ((r == 16) ? 9 : 0), "pause_note");
        end
        for (int r = 3; r <= 16; r++) sb_push(r, S_NSTART, (r == 16) ? 1 : 0, "pause_nstart");
        sb_push(8, S_BUSY, 1, "pause_busy");
        tick(); start = 1'b0;
        goto_rel(3); pause = 1'b1;
        goto_rel(13); pause = 1'b0;
        stop_main(17);

        // start and stop together from IDLE
        base = cyc; start = 1'b1; stop = 1'b1;
        sb_push(1, S_BUSY, 0, "race_busy"); sb_push(2, S_BUSY, 0, "race_busy");
        sb_push(1, S_NOTE, 0, "race_note"); sb_push(1, S_ADDR, 1, "race_addr");
        tick(); start = 1'b0; stop = 1'b0;
        goto_rel(3);

        // Restart during PLAY at rom_addr=20
        clear_tbl();
        tbl[1] = 4'd10; tbl[2] = 4'd10; tbl[19] = 4'd10; tbl[20] = 4'd10;
        step_len = 24'd1;
        base = cyc; start = 1'b1;
        sb_push(20, S_ADDR, 20, "restart_addr"); sb_push(21, S_ADDR, 1, "restart_addr");
        sb_push(22, S_ADDR, 2, "restart_addr");
        sb_push(20, S_NSTART, 1, "restart_nstart"); sb_push(21, S_NSTART, 0, "restart_nstart");
        sb_push(22, S_NSTART, 1, "restart_nstart"); sb_push(23, S_NSTART, 0, "restart_nstart");
        sb_push(21, S_NOTE, 0, "restart_note"); sb_push(22, S_NOTE, 10, "restart_note");
        tick(); start = 1'b0;
        goto_rel(20); start = 1'b1;
        tick(); start = 1'b0;
        stop_main(24);

        // Reset mid-play at rom_addr=30
        clear_tbl();
        tbl[29] = 4'd8; tbl[30] = 4'd9;
        step_len = 24'd1;
        base = cyc; start = 1'b1;
        sb_push(30, S_ADDR, 30, "midrst_addr"); sb_push(30, S_NOTE, 8, "midrst_note");
        sb_push(30, S_NSTART, 1, "midrst_nstart");
        sb_push(31, S_ADDR, 1, "midrst_addr"); sb_push(31, S_NOTE, 0, "midrst_note");
        sb_push(31, S_VALID, 0, "midrst_valid"); sb_push(31, S_NSTART, 0, "midrst_nstart");
        sb_push(31, S_BUSY, 0, "midrst_busy"); sb_push(31, S_DONE, 0, "midrst_done");
        tick(); start = 1'b0;
        goto_rel(30); rst = 1'b1;
        tick(); rst = 1'b0;
        goto_rel(33);

        // step_len=0 behaves as one-clock steps
        clear_tbl();
        tbl[1] = 4'd8; tbl[2] = 4'd9; tbl[3] = 4'd9;
        step_len = '0;
        base = cyc; start = 1'b1;
        sb_push(1, S_ADDR, 1, "len0_addr"); sb_push(2, S_ADDR, 2, "len0_addr");
        sb_push(3, S_ADDR, 3, "len0_addr");
        sb_push(2, S_NOTE, 8, "len0_note"); sb_push(3, S_NOTE, 9, "len0_note");
        sb_push(4, S_NOTE, 9, "len0_note");
        sb_push(2, S_NSTART, 1, "len0_nstart"); sb_push(3, S_NSTART, 1, "len0_nstart");
        sb_push(4, S_NSTART, 0, "len0_nstart"); sb_push(5, S_NSTART, 0, "len0_nstart");
        tick(); start = 1'b0;
        stop_main(6);

        // Maximum step_len; later step_len changes are ignored
        clear_tbl();
        tbl[1] = 4'd8; tbl[2] = 4'd9;
        step_len = '1;
        base = cyc; start = 1'b1;
        sb_push(1, S_ADDR, 1, "maxlen_addr"); sb_push(300, S_ADDR, 1, "maxlen_addr");
        sb_push(300, S_BUSY, 1, "maxlen_busy"); sb_push(300, S_NOTE, 8, "maxlen_note");
        sb_push(300, S_NSTART, 0, "maxlen_nstart");
        tick(); start = 1'b0;
        goto_rel(2); step_len = 24'd1;
        stop_main(301);

        // One-shot end on LAST_ADDR=3 instance
        clear_tbl();
        tbl3[1] = 4'd8; tbl3[3] = 4'd8;
        step_len = 24'd2; loop_en = 1'b0;
        base = cyc; start3 = 1'b1;
        for (int r = 1; r <= 8; r++) sb_push(r, S_DONE3, (r == 7) ? 1 : 0, "oneshot_done");
        sb_push(6, S_BUSY3, 1, "oneshot_busy"); sb_push(7, S_BUSY3, 0, "oneshot_busy");
        sb_push(6, S_NSTART3, 1, "oneshot_nstart");
        sb_push(7, S_NOTE3, 8, "oneshot_note"); sb_push(8, S_NOTE3, 0, "oneshot_note");
        sb_push(7, S_ADDR3, 1, "oneshot_addr");
        tick(); start3 = 1'b0;
        goto_rel(10);

        // Looping on LAST_ADDR=3 instance
        loop_en = 1'b1;
        base = cyc; start3 = 1'b1;
        sb_push(2, S_NSTART3, 1, "loop_nstart"); sb_push(6, S_NSTART3, 1, "loop_nstart");
        sb_push(8, S_NSTART3, 1, "loop_nstart");
        sb_push(7, S_DONE3, 0, "loop_done"); sb_push(8, S_DONE3, 0, "loop_done");
        sb_push(7, S_BUSY3, 1, "loop_busy"); sb_push(9, S_BUSY3, 1, "loop_busy");
        sb_push(7, S_ADDR3, 1, "loop_addr"); sb_push(9, S_ADDR3, 2, "loop_addr");
        sb_push(11, S_BUSY3, 0, "loop_stop_busy");
        tick(); start3 = 1'b0;
        goto_rel(10); stop3 = 1'b1;
        tick(); stop3 = 1'b0;
        goto_rel(13);
        loop_en = 1'b0;

        tick(); tick();
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "_unreached"}, -1, mon_e.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
